// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with start/done handshake.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |dividend|<|divisor| bypass CALC.
module iter_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  kill,
    input  logic [1:0]            div_op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
    logic [W-1:0]  result_q, result_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic          in_signed;
    logic [W-1:0]  a_abs, b_abs;
    logic [W:0]    ext;
    logic          ge;
    logic [W-1:0]  diff, rem_nx, quo_nx;

    // Special cases always win over the iterated magnitudes.
    function automatic logic [W-1:0] fmt_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [W-1:0] q,
                                                input logic [W-1:0] r);
        logic sgn;
        sgn = ~op[0];
        if (b == '0)
            fmt_result = op[1] ? a : '1;
        else if (sgn && a == MIN_NEG && b == '1)
            fmt_result = op[1] ? '0 : a;
        else if (op[1])
            fmt_result = (sgn && a[W-1]) ? (W'(0) - r) : r;
        else
            fmt_result = (sgn && (a[W-1] ^ b[W-1])) ? (W'(0) - q) : q;
    endfunction

    assign in_signed = ~div_op[0];
    assign a_abs     = (in_signed && dividend[W-1]) ? (W'(0) - dividend) : dividend;
    assign b_abs     = (in_signed && divisor[W-1])  ? (W'(0) - divisor)  : divisor;

    // Partial remainder needs one extra bit before the trial subtraction.
    assign ext    = {rem_q, quo_q[W-1]};
    assign ge     = (ext >= {1'b0, dvs_q});
    assign diff   = ext[W-1:0] - dvs_q;
    assign rem_nx = ge ? diff : ext[W-1:0];
    assign quo_nx = {quo_q[W-2:0], ge};

`ifdef DIV_EARLY_OUT_EN
    logic early;
    assign early = (divisor == '0) ||
                   (in_signed && dividend == MIN_NEG && divisor == '1) ||
                   (a_abs < b_abs);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        op_d  = div_op;
                        a_d   = dividend;
                        b_d   = divisor;
                        dvs_d = b_abs;
                        rem_d = '0;
                        quo_d = a_abs;
                        cnt_d = CW'(W - 1);
`ifdef DIV_EARLY_OUT_EN
                        if (early) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            result_d = fmt_result(div_op, dividend, divisor, '0, a_abs);
                        end else begin
                            state_d = CALC;
                            busy_d  = 1'b1;
                        end
`else
                        state_d = CALC;
                        busy_d  = 1'b1;
`endif
                    end
                end
                CALC: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = fmt_result(op_q, a_q, b_q, quo_nx, rem_nx);
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        busy_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
